// File: rtl/inv_bist_checker_if.sv
// Bus between the inverter self-test controller and the gate under test.
// master: the checker (drives the gate input and the verdict).
// slave : the gate/environment side (drives start and the gate output).
interface inv_bist_checker_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             x_out;
  logic             f_in;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [7:0]       fail_idx;

  modport master (
    input  start, f_in,
    output x_out, busy, done, pass, err_cnt, fail_idx
  );

  modport slave (
    output start, f_in,
    input  x_out, busy, done, pass, err_cnt, fail_idx
  );
endinterface

// File: rtl/inv_bist_checker.sv
// Self-test controller for a CMOS inverter: drives 0,1,0,1,... on x_out,
// waits SETTLE_CYC cycles per vector, checks f_in == ~x_out and reports
// a saturating mismatch count, the first failing vector and a verdict.
module inv_bist_checker #(
  parameter int SETTLE_CYC = 4,
  parameter int NUM_VEC    = 4,
  parameter int ERR_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  inv_bist_checker_if.master  bus
);

  localparam int              CNT_W       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [7:0]       LAST_VEC    = 8'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;
  localparam logic [7:0]       IDX_NONE    = 8'hFF;

  typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, DONE} state_e;

  state_e           state_q, state_d;
  logic             x_out_q, x_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [7:0]       fail_idx_q, fail_idx_d;
  logic [7:0]       vec_idx_q, vec_idx_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             mismatch;

  // Next-state and next-output logic; busy/done are registered from the
  // upcoming state so they line up exactly with the state they describe.
  always_comb begin
    state_d      = state_q;
    x_out_d      = x_out_q;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
    fail_idx_d   = fail_idx_q;
    vec_idx_d    = vec_idx_q;
    settle_cnt_d = settle_cnt_q;
    mismatch     = (bus.f_in != ~x_out_q);

    case (state_q)
      IDLE: begin
        x_out_d = 1'b0;
        if (bus.start) begin
          err_cnt_d  = '0;
          fail_idx_d = IDX_NONE;
          pass_d     = 1'b0;
          vec_idx_d  = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        x_out_d      = vec_idx_q[0];
        settle_cnt_d = SETTLE_LOAD;
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt_q == '0) state_d = SAMPLE;
        else                    settle_cnt_d = settle_cnt_q - 1'b1;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 1'b1;
          // vec_idx never reaches 8'hFF, so the sentinel marks "no failure yet"
          if (fail_idx_q == IDX_NONE) fail_idx_d = vec_idx_q;
        end
        if (vec_idx_q == LAST_VEC) begin
          state_d = DONE;
        end else begin
          vec_idx_d = vec_idx_q + 8'd1;
          state_d   = DRIVE;
        end
      end
      DONE: begin
        pass_d  = (err_cnt_q == '0);
        x_out_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_out_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      fail_idx_q   <= IDX_NONE;
      vec_idx_q    <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      x_out_q      <= x_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
      fail_idx_q   <= fail_idx_d;
      vec_idx_q    <= vec_idx_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign bus.x_out    = x_out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.fail_idx = fail_idx_q;

endmodule

// File: doc/inv_bist_checker.md
Name: inv_bist_checker

Overview:
Synthesizable self-test controller for an on-chip CMOS inverter (x -> f).
- Applies an alternating 0,1,0,1,... vector sequence to the gate input.
- Waits a programmable settle time, then samples the gate output and checks f == ~x.
- Reports mismatch count, the index of the first failing vector, and a pass/fail verdict.
- Sits beside the gate under test and gives a hardware check of inverter function.

Parameters:
- SETTLE_CYC, 4: cycles x_out is held before f_in is sampled. Legal range: >= 1.
- NUM_VEC, 4: vectors per run. Legal range: 1..255. Vector k drives x = k[0].
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- start  in  1: run request; sampled only in IDLE.
- x_out  out  1: registered drive to the inverter input.
- f_in  in  1: inverter output; must be synchronous to clk or settle within SETTLE_CYC.
- busy  out  1: high in every state except IDLE.
- done  out  1: one-cycle pulse when the verdict is valid.
- pass  out  1: high when the last run had err_cnt == 0; held until the next start or reset.
- err_cnt  out  ERR_W: number of mismatches in the last or current run; saturating.
- fail_idx  out  8: index of the first mismatching vector; 8'hFF means none.

Behaviour:
- Reset values (rst=1, asynchronous): state=IDLE, x_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_idx=8'hFF, vec_idx=0, settle counter=0.
- Reset mid-run aborts the run immediately. No done pulse is produced. The next run needs a fresh start.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE:
  - x_out=0.
  - On start=1: clear err_cnt, set fail_idx=8'hFF, clear pass, set vec_idx=0, go to DRIVE.
- DRIVE (1 cycle):
  - x_out <= vec_idx[0].
  - Load the settle counter with SETTLE_CYC-1.
  - Go to SETTLE.
- SETTLE (SETTLE_CYC cycles):
  - Decrement the counter.
  - Go to SAMPLE on the cycle the counter is 0.
- SAMPLE (1 cycle). Mismatch is f_in != ~x_out. On a mismatch:
  - err_cnt increments, saturating at 2^ERR_W-1.
  - If no earlier mismatch in this run, fail_idx <= vec_idx.
  - Next state: if vec_idx == NUM_VEC-1, go to DONE; otherwise vec_idx++ and go to DRIVE.
- DONE (1 cycle):
  - done=1.
  - pass <= (err_cnt == 0), where err_cnt already includes the final sample.
  - x_out <= 0.
  - Go to IDLE.
- Timing:
  - Each vector takes SETTLE_CYC+2 cycles.
  - If start is sampled at edge 0, DONE is the state during cycle NUM_VEC*(SETTLE_CYC+2)+1. With the defaults that is cycle 25.
- start while busy=1 is ignored. It is not queued.
- start in the same cycle that DONE returns to IDLE is not seen. start is accepted only while in IDLE.
- Saturation: err_cnt holds at its maximum value. fail_idx is unaffected by saturation.
- err_cnt, fail_idx and pass hold their values in IDLE until the next accepted start.

Test Plan:
- Healthy inverter model (f = ~x, 1-cycle delay), defaults, start pulse at cycle 0 -> done pulse in cycle 25, pass=1, err_cnt=0, fail_idx=8'hFF; x_out sequence 0,1,0,1, then 0 in IDLE.
- f_in stuck at 0, defaults -> err_cnt=2, fail_idx=0, pass=0.
- f_in stuck at 1 -> err_cnt=2, fail_idx=1, pass=0.
- Buffer model (f = x) with ERR_W=2, NUM_VEC=8 -> err_cnt saturates at 3, fail_idx=0, pass=0.
- Slow gate (f = ~x delayed 6 cycles), SETTLE_CYC=4 -> every vector after the first reads the stale value: err_cnt=3, fail_idx=1. With SETTLE_CYC=6 the same model gives err_cnt=0, pass=1.
- Start during busy (cycle 5) -> no restart, done still in cycle 25. Then rst pulse at cycle 10 of a second run -> all outputs return to reset values, no done pulse, and a new start gives a normal full run.
